// File: rtl/stream_checker.sv
// rtl/stream_checker.sv - valid/ready stream sink checking an incrementing word sequence
module stream_checker #(
    parameter int          DATA_W    = 8,
    parameter int          NUM_WORDS = 16,
    parameter logic [31:0] START_VAL = 32'd0,
    parameter logic [7:0]  READY_PAT = 8'b1111_1111
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       rx_count,
    output logic [15:0]       err_count,
    output logic [15:0]       first_err_idx,
    output logic [DATA_W-1:0] first_err_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // An all-zero mask would never offer ready, so it degrades to always-ready.
    localparam logic [7:0]        PAT_INIT = (READY_PAT == 8'h00) ? 8'hFF : READY_PAT;
    localparam logic [DATA_W-1:0] START_W  = START_VAL[DATA_W-1:0];
    localparam logic [16:0]       LAST_CNT = 17'(NUM_WORDS);

    state_t            state_q, state_d;
    logic [7:0]        pat_q, pat_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [15:0]       rx_q, rx_d;
    logic [15:0]       err_q, err_d;
    logic [15:0]       ferr_idx_q, ferr_idx_d;
    logic [DATA_W-1:0] ferr_data_q, ferr_data_d;

    logic              xfer;
    logic [16:0]       rx_inc;

    assign xfer   = s_valid & ready_q;
    assign rx_inc = {1'b0, rx_q} + 17'd1;

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        exp_d       = exp_q;
        ready_d     = ready_q;
        done_d      = done_q;
        pass_d      = pass_q;
        rx_d        = rx_q;
        err_d       = err_q;
        ferr_idx_d  = ferr_idx_q;
        ferr_data_d = ferr_data_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    exp_d       = START_W;
                    // Bit 0 is consumed as the first ready, so the register starts pre-rotated.
                    ready_d     = PAT_INIT[0];
                    pat_d       = {PAT_INIT[0], PAT_INIT[7:1]};
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    rx_d        = 16'd0;
                    err_d       = 16'd0;
                    ferr_idx_d  = 16'd0;
                    ferr_data_d = '0;
                end
            end
            ST_RUN: begin
                ready_d = pat_q[0];
                pat_d   = {pat_q[0], pat_q[7:1]};
                if (xfer) begin
                    rx_d  = rx_inc[15:0];
                    exp_d = exp_q + DATA_W'(1);
                    if (s_data != exp_q) begin
                        err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
                        if (err_q == 16'd0) begin
                            ferr_idx_d  = rx_q;
                            ferr_data_d = s_data;
                        end
                    end
                    if (rx_inc == LAST_CNT) begin
                        state_d = ST_DONE;
                        ready_d = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 16'd0);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b0;
            end
        endcase

        busy_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pat_q       <= PAT_INIT;
            exp_q       <= START_W;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            rx_q        <= 16'd0;
            err_q       <= 16'd0;
            ferr_idx_q  <= 16'd0;
            ferr_data_q <= '0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            exp_q       <= exp_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            rx_q        <= rx_d;
            err_q       <= err_d;
            ferr_idx_q  <= ferr_idx_d;
            ferr_data_q <= ferr_data_d;
        end
    end

    assign s_ready        = ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign rx_count       = rx_q;
    assign err_count      = err_q;
    assign first_err_idx  = ferr_idx_q;
    assign first_err_data = ferr_data_q;

endmodule
